// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: single-outstanding instruction fetcher feeding an instruction queue,
// with redirect flush, one-word hold buffer for a full queue, and push/drop counters.
module fetch_prefetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ic_req_valid,
  output logic [31:0] ic_req_addr,
  input  logic        ic_req_ready,
  input  logic        ic_rsp_valid,
  input  logic [31:0] ic_rsp_data,
  input  logic        q_full,
  output logic        q_push,
  output logic [31:0] q_push_data,
  output logic [31:0] q_push_pc,
  output logic [15:0] push_count,
  output logic [15:0] drop_count
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic [31:0] hold_data_q, hold_data_d, hold_pc_q, hold_pc_d;
  logic [15:0] push_cnt_q, drop_cnt_q;
  logic        drop;
  assign ic_req_addr = pc_q & 32'hFFFF_FFFC;
  assign push_count  = push_cnt_q;
  assign drop_count  = drop_cnt_q;
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    hold_data_d  = hold_data_q;
    hold_pc_d    = hold_pc_q;
    ic_req_valid = 1'b0;
    q_push       = 1'b0;
    q_push_data  = hold_data_q;
    q_push_pc    = hold_pc_q;
    drop         = 1'b0;
    case (state_q)
      S_REQ: begin
        // rst_n gating keeps the request quiet while reset is held
        ic_req_valid = rst_n && !redirect_valid;
        if (redirect_valid) pc_d = redirect_pc;
        else if (ic_req_ready) begin
          req_pc_d = ic_req_addr;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        q_push_data = ic_rsp_data;
        q_push_pc   = req_pc_q;
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          drop    = ic_rsp_valid;
          state_d = ic_rsp_valid ? S_REQ : S_DROP;
        end else if (ic_rsp_valid && !q_full) begin
          q_push  = 1'b1;
          pc_d    = req_pc_q + 32'd4;
          state_d = S_REQ;
        end else if (ic_rsp_valid) begin
          hold_data_d = ic_rsp_data;
          hold_pc_d   = req_pc_q;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          drop    = 1'b1;
          state_d = S_REQ;
        end else if (!q_full) begin
          q_push  = 1'b1;
          pc_d    = hold_pc_q + 32'd4;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect_valid) pc_d = redirect_pc;
        if (ic_rsp_valid) begin
          drop    = 1'b1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      hold_data_q <= '0;
      hold_pc_q   <= '0;
      push_cnt_q  <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      hold_data_q <= hold_data_d;
      hold_pc_q   <= hold_pc_d;
      push_cnt_q  <= push_cnt_q + {15'd0, q_push};
      drop_cnt_q  <= drop_cnt_q + {15'd0, drop};
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: directed scenarios for fetch_prefetch_unit; inputs change on
// the falling edge and outputs are sampled 1ns later, state advances on the rising edge.
module tb_fetch_prefetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ic_req_valid;
  logic [31:0] ic_req_addr;
  logic        ic_req_ready = 1'b0;
  logic        ic_rsp_valid = 1'b0;
  logic [31:0] ic_rsp_data = '0;
  logic        q_full = 1'b0;
  logic        q_push;
  logic [31:0] q_push_data, q_push_pc;
  logic [15:0] push_count, drop_count;
  int n_checks = 0;
  int n_fail = 0;

  fetch_prefetch_unit dut (
    .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data), .q_full(q_full),
    .q_push(q_push), .q_push_data(q_push_data), .q_push_pc(q_push_pc),
    .push_count(push_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd, input logic full,
                       input logic redir, input logic [31:0] rpc);
    @(negedge clk);
    ic_req_ready = rdy; ic_rsp_valid = rv; ic_rsp_data = rd; q_full = full;
    redirect_valid = redir; redirect_pc = rpc;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ic_req_ready = 0; ic_rsp_valid = 0; ic_rsp_data = '0; q_full = 0; redirect_valid = 0; redirect_pc = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive(0, 0, '0, 0, 0, '0);
    n_checks++; if (ic_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid got %b exp 0", ic_req_valid); end
    n_checks++; if (q_push !== 1'b0) begin n_fail++; $display("FAIL reset_q_push got %b exp 0", q_push); end
    n_checks++; if (ic_req_addr !== 32'h0040_0000) begin n_fail++; $display("FAIL reset_addr got %h exp 00400000", ic_req_addr); end
    n_checks++; if (push_count !== 16'd0 || drop_count !== 16'd0) begin n_fail++; $display("FAIL reset_counts got %0d/%0d exp 0/0", push_count, drop_count); end
    @(negedge clk);
    rst_n = 1'b1; ic_req_ready = 1'b1;
    #1;
    n_checks++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h0040_0000) begin n_fail++; $display("FAIL first_req got %b %h exp 1 00400000", ic_req_valid, ic_req_addr); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, '0, 0, 0, '0);
      n_checks++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h0040_0000 + 32'(4 * i)) begin n_fail++; $display("FAIL stream_req%0d got %b %h exp 1 %h", i, ic_req_valid, ic_req_addr, 32'h0040_0000 + 32'(4 * i)); end
      drive(1, 1, 32'h1000_0000 + 32'(i), 0, 0, '0);
      n_checks++; if (q_push !== 1'b1 || q_push_pc !== 32'h0040_0000 + 32'(4 * i) || q_push_data !== 32'h1000_0000 + 32'(i)) begin n_fail++; $display("FAIL stream_push%0d got %b %h %h exp 1 %h %h", i, q_push, q_push_pc, q_push_data, 32'h0040_0000 + 32'(4 * i), 32'h1000_0000 + 32'(i)); end
      n_checks++; if (ic_req_valid !== 1'b0) begin n_fail++; $display("FAIL stream_wait_valid%0d got %b exp 0", i, ic_req_valid); end
    end
    drive(0, 0, '0, 0, 0, '0);
    n_checks++; if (push_count !== 16'd3 || ic_req_addr !== 32'h0040_000C) begin n_fail++; $display("FAIL stream_count got %0d %h exp 3 0040000c", push_count, ic_req_addr); end
  endtask

  task automatic test_hold();
    do_reset();
    drive(1, 0, '0, 1, 0, '0);
    drive(0, 1, 32'h8C01_0004, 1, 0, '0);
    n_checks++; if (q_push !== 1'b0) begin n_fail++; $display("FAIL hold_full_push got %b exp 0", q_push); end
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, '0, 1, 0, '0);
      n_checks++; if (q_push !== 1'b0 || ic_req_valid !== 1'b0) begin n_fail++; $display("FAIL hold_wait%0d got push %b req %b exp 0 0", i, q_push, ic_req_valid); end
    end
    drive(0, 0, '0, 0, 0, '0);
    n_checks++; if (q_push !== 1'b1 || q_push_data !== 32'h8C01_0004 || q_push_pc !== 32'h0040_0000) begin n_fail++; $display("FAIL hold_push got %b %h %h exp 1 8c010004 00400000", q_push, q_push_data, q_push_pc); end
    drive(0, 0, '0, 0, 0, '0);
    n_checks++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h0040_0004 || push_count !== 16'd1 || drop_count !== 16'd0) begin n_fail++; $display("FAIL hold_next got %b %h %0d %0d exp 1 00400004 1 0", ic_req_valid, ic_req_addr, push_count, drop_count); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    drive(1, 0, '0, 0, 0, '0);
    drive(0, 0, '0, 0, 1, 32'h0000_1002);
    n_checks++; if (q_push !== 1'b0 || ic_req_valid !== 1'b0) begin n_fail++; $display("FAIL redir_wait got push %b req %b exp 0 0", q_push, ic_req_valid); end
    drive(1, 0, '0, 0, 0, '0);
    n_checks++; if (ic_req_valid !== 1'b0) begin n_fail++; $display("FAIL redir_drop_req got %b exp 0", ic_req_valid); end
    drive(1, 1, 32'hDEAD_BEEF, 0, 0, '0);
    n_checks++; if (q_push !== 1'b0) begin n_fail++; $display("FAIL redir_stale_push got %b exp 0", q_push); end
    drive(0, 0, '0, 0, 0, '0);
    n_checks++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL redir_next got %b %h exp 1 00001000", ic_req_valid, ic_req_addr); end
    n_checks++; if (drop_count !== 16'd1 || push_count !== 16'd0) begin n_fail++; $display("FAIL redir_counts got %0d %0d exp 1 0", drop_count, push_count); end
  endtask

  task automatic test_redirect_same();
    do_reset();
    drive(1, 0, '0, 0, 0, '0);
    drive(0, 1, 32'h1234_5678, 0, 1, 32'h2000_0040);
    n_checks++; if (q_push !== 1'b0) begin n_fail++; $display("FAIL same_push got %b exp 0", q_push); end
    drive(0, 0, '0, 0, 0, '0);
    n_checks++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h2000_0040 || drop_count !== 16'd1) begin n_fail++; $display("FAIL same_next got %b %h %0d exp 1 20000040 1", ic_req_valid, ic_req_addr, drop_count); end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(1, 0, '0, 0, 1, 32'hFFFF_FFFC);
    n_checks++; if (ic_req_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_redir_req got %b exp 0", ic_req_valid); end
    drive(1, 0, '0, 0, 0, '0);
    n_checks++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_req got %b %h exp 1 fffffffc", ic_req_valid, ic_req_addr); end
    drive(0, 1, 32'hCAFE_0001, 0, 0, '0);
    n_checks++; if (q_push !== 1'b1 || q_push_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_push got %b %h exp 1 fffffffc", q_push, q_push_pc); end
    drive(0, 0, '0, 0, 0, '0);
    n_checks++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_next got %b %h exp 1 00000000", ic_req_valid, ic_req_addr); end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1, 0, '0, 0, 0, '0);
    drive(1, 1, 32'h0BAD_F00D, 0, 0, '0);
    drive(1, 0, '0, 0, 0, '0);
    n_checks++; if (push_count !== 16'd1 || ic_req_addr !== 32'h0040_0004) begin n_fail++; $display("FAIL areset_pre got %0d %h exp 1 00400004", push_count, ic_req_addr); end
    @(negedge clk);
    ic_req_ready = 0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (ic_req_valid !== 1'b0 || q_push !== 1'b0 || push_count !== 16'd0 || ic_req_addr !== 32'h0040_0000) begin n_fail++; $display("FAIL areset_now got %b %b %0d %h exp 0 0 0 00400000", ic_req_valid, q_push, push_count, ic_req_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1, 32'h5555_AAAA, 0, 0, '0);
    n_checks++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 32'h0040_0000 || q_push !== 1'b0) begin n_fail++; $display("FAIL areset_first got %b %h %b exp 1 00400000 0", ic_req_valid, ic_req_addr, q_push); end
    drive(0, 0, '0, 0, 0, '0);
    n_checks++; if (ic_req_valid !== 1'b1 || drop_count !== 16'd0 || push_count !== 16'd0) begin n_fail++; $display("FAIL areset_late_rsp got %b %0d %0d exp 1 0 0", ic_req_valid, drop_count, push_count); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_hold();
    test_redirect_wait();
    test_redirect_same();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
